// File: rtl/seg7_readback_decoder_if.sv
// rtl/seg7_readback_decoder_if.sv - seven-segment bus and readback result bundle
interface seg7_readback_decoder_if #(
   parameter int DIGITS = 4
);
   logic [6:0]          seg;
   logic [DIGITS-1:0]   sel;
   logic [4*DIGITS-1:0] value;
   logic                value_valid;
   logic [DIGITS-1:0]   bad;
   logic                sel_err;
   logic [7:0]          frame_count;

   modport master (
      output seg, sel,
      input  value, value_valid, bad, sel_err, frame_count
   );

   modport slave (
      input  seg, sel,
      output value, value_valid, bad, sel_err, frame_count
   );
endinterface

// File: rtl/seg7_readback_decoder.sv
// rtl/seg7_readback_decoder.sv - rebuilds the hex word shown on a multiplexed active-low 7-segment display
module seg7_readback_decoder #(
   parameter int DIGITS = 4,
   parameter int SETTLE = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   seg7_readback_decoder_if.slave  bus
);
   localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_C    = CW'(SETTLE);
   localparam logic [CW-1:0] SETTLE_M1_C = CW'(SETTLE - 1);

   logic [DIGITS-1:0]   r_sel_q;
   logic [6:0]          r_seg_q;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   badm_q, badm_d;
   logic [4*DIGITS-1:0] value_q, value_d;
   logic [DIGITS-1:0]   bad_q, bad_d;
   logic                valid_q, valid_d;
   logic                sel_err_q, sel_err_d;
   logic [7:0]          fc_q, fc_d;

   logic                same;
   logic                cap;
   logic [DIGITS-1:0]   sel_lo;
   logic                single_lo;
   logic                multi_lo;
   logic [4:0]          dec;

   // Inverse of the hex-to-segment encoding; bit 4 flags an undecodable pattern.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = 5'h00;
         7'b1111001: decode = 5'h01;
         7'b0100100: decode = 5'h02;
         7'b0110000: decode = 5'h03;
         7'b0011001: decode = 5'h04;
         7'b0010010: decode = 5'h05;
         7'b0000010: decode = 5'h06;
         7'b1111000: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0010000: decode = 5'h09;
         7'b0001000: decode = 5'h0A;
         7'b0000011: decode = 5'h0B;
         7'b1000110: decode = 5'h0C;
         7'b0100001: decode = 5'h0D;
         7'b0000110: decode = 5'h0E;
         7'b0001110: decode = 5'h0F;
         default:    decode = 5'h10;
      endcase
   endfunction

   always_comb begin
      same  = ({bus.sel, bus.seg} == {r_sel_q, r_seg_q});
      cnt_d = cnt_q;
      if (!same)
         cnt_d = '0;
      else if (cnt_q != SETTLE_C)
         cnt_d = cnt_q + CW'(1);
      // Fires only on the SETTLE-1 -> SETTLE step, so a held input captures once.
      cap = same && (cnt_q == SETTLE_M1_C);
   end

   always_comb begin
      sel_lo    = ~r_sel_q;
      single_lo = (sel_lo != '0) && ((sel_lo & (sel_lo - DIGITS'(1))) == '0);
      multi_lo  = (sel_lo != '0) && !single_lo;
      dec       = decode(r_seg_q);
   end

   always_comb begin
      digits_d  = digits_q;
      badm_d    = badm_q;
      mask_d    = mask_q;
      value_d   = value_q;
      bad_d     = bad_q;
      valid_d   = 1'b0;
      sel_err_d = 1'b0;
      fc_d      = fc_q;
      if (cap) begin
         if (multi_lo) begin
            sel_err_d = 1'b1;
         end else if (single_lo) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (sel_lo[i]) begin
                  digits_d[4*i +: 4] = dec[4] ? 4'h0 : dec[3:0];
                  badm_d[i]          = dec[4];
               end
            end
            // Completing digit is folded into the published word on the same edge.
            if ((mask_q | sel_lo) == {DIGITS{1'b1}}) begin
               value_d = digits_d;
               bad_d   = badm_d;
               valid_d = 1'b1;
               fc_d    = fc_q + 8'd1;
               mask_d  = '0;
            end else begin
               mask_d = mask_q | sel_lo;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_q   <= '1;
         r_seg_q   <= '1;
         cnt_q     <= '0;
         mask_q    <= '0;
         digits_q  <= '0;
         badm_q    <= '0;
         value_q   <= '0;
         bad_q     <= '0;
         valid_q   <= 1'b0;
         sel_err_q <= 1'b0;
         fc_q      <= '0;
      end else begin
         r_sel_q   <= bus.sel;
         r_seg_q   <= bus.seg;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         digits_q  <= digits_d;
         badm_q    <= badm_d;
         value_q   <= value_d;
         bad_q     <= bad_d;
         valid_q   <= valid_d;
         sel_err_q <= sel_err_d;
         fc_q      <= fc_d;
      end
   end

   assign bus.value       = value_q;
   assign bus.value_valid = valid_q;
   assign bus.bad         = bad_q;
   assign bus.sel_err     = sel_err_q;
   assign bus.frame_count = fc_q;
endmodule

// File: doc/seg7_readback_decoder.md
# seg7_readback_decoder

Monitors the multiplexed, active-low 7-segment bus (segment lines plus digit selects) driven to the Alchitry Io board. It inverts the hex-to-segment encoding, rebuilding the displayed hex value one digit at a time. After every digit of a scan frame has been captured, it publishes the assembled word with a one-cycle valid strobe. It sits beside the display driver and is used for on-chip readback of what the display shows and for self-checking in lab builds.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits; digit 0 is least significant.
- SETTLE, 4, consecutive matching samples required before a capture (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg  in  7  segment lines, active low, {g,f,e,d,c,b,a} (bit 0 = a).
- sel  in  DIGITS  digit selects, active low; bit i low selects digit i.
- value  out  4*DIGITS  last complete frame; digit i in bits [4i+3:4i]. Reset 0.
- value_valid  out  1  one-cycle pulse when value is updated. Reset 0.
- bad  out  DIGITS  per-digit flag for an undecodable pattern in the last frame. Reset 0.
- sel_err  out  1  one-cycle pulse when a stable sel has more than one bit low. Reset 0.
- frame_count  out  8  number of completed frames, wraps 255→0. Reset 0.

## Operation
- Sample registers r_sel and r_seg load sel and seg every cycle. Reset value is all ones for both.
- Stability counter cnt (width clog2(SETTLE+1)), updated each edge:
  - If {sel,seg} ≠ {r_sel,r_seg}: cnt←0.
  - Else if cnt≠SETTLE: cnt←cnt+1.
  - Else: cnt holds at SETTLE.
- A capture event fires on the edge where cnt goes SETTLE−1→SETTLE. It fires once per stable interval; no repeat captures while the inputs are held.
- At a capture event, sel is classified:
  - All ones: blank, ignored.
  - Exactly one bit low (index i): digit capture.
  - Two or more bits low: sel_err pulses for one cycle. No capture takes place.
- Digit capture decodes seg by inverting the encoding below.
  - digit[i] is loaded with the nibble and badm[i] with 0.
  - Any other pattern (including blank 1111111) loads digit[i]←0 and badm[i]←1.
  - mask[i] is set.
- Decode table, seg→nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3.
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7.
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B.
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F.
- Frame complete is detected on the same capture edge: when (mask | 1<<i) is all ones:
  - value ← digits including the new one.
  - bad ← badm including the new bit.
  - value_valid ← 1 for one cycle.
  - frame_count ← frame_count+1.
  - mask ← 0.
- Recapturing a digit already in mask overwrites digit[i] and badm[i]. mask and outputs are unchanged.
- Digits may arrive in any order. A frame is complete when all DIGITS selects have been captured at least once since the last publish.

## Timing
- Inputs change before edge E0 and are then held. Edge E0 loads r_* and clears cnt. Edges E1…E_SETTLE raise cnt to SETTLE, and the capture occurs at E_SETTLE.
- With SETTLE=4, capture happens on the 5th edge after the change, so inputs must be held for 5 cycles.
- value, bad, frame_count and value_valid become visible in the cycle after the completing capture edge. value_valid deasserts one cycle later.
- A glitch of one or more cycles restarts the count. A glitch shorter than SETTLE+1 cycles never captures.
- value and bad hold until the next complete frame.
- rst_n low (asynchronous, any time including mid-frame) clears every register and output immediately: r_*=all ones, cnt=0, mask=0, digits=0, badm=0, outputs at the reset values above. Counting and capture resume on the first edge after rst_n rises.

## Test plan
- Drive digits 0..3 as patterns for 4,3,2,1 (sel 1110,1101,1011,0111), 8 cycles each → value=0x1234, bad=0000, one value_valid pulse, frame_count=1.
- Digit 2 shows 1111111 within a frame of 0xABCD patterns → value=0xA0CD, bad=0100.
- Digit hold of exactly SETTLE cycles, then a change → no capture. Hold of SETTLE+1 cycles → capture on the 5th edge; frame valid timing checked to the cycle.
- sel=1100 held 8 cycles → one sel_err pulse, mask unchanged. sel=1111 held → nothing happens.
- Digit 0 shown twice (first 5, then 9) before digits 1–3 (0,0,0) → value=0x0009, with a single value_valid pulse.
- rst_n pulsed low after digits 0–2 are captured, then a full frame of 0xFFFF is sent → all outputs 0 during reset. Afterwards value=0xFFFF, frame_count=1, and no early valid occurs from the pre-reset mask.
